note_sequencer: RTL and testbench

Queues note events and drives the note_on/note_off side of envelope_generator, then waits for the envelope's done before starting the next note. Events (peak level plus hold length) enter through a valid/ready port into a small FIFO. For each event the block issues one note_on pulse, holds for the requested cycles, issues one note_off pulse, and waits for release to finish. It sits between the control/MIDI front end and envelope_generator, and supplies that generator's peak level (b) per note.

---
 rtl/note_sequencer.sv | 137 +++++++++++++
 tb/tb_note_sequencer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_sequencer.sv
// Note-event sequencer: buffers {peak, hold} events and plays each through
// envelope_generator as a note_on / hold / note_off / wait-for-done cycle.
module note_sequencer #(
    parameter int DEPTH  = 4,
    parameter int HOLD_W = 32
) (
    input  logic                     clk,
    input  logic                     rst_b,
    input  logic                     ev_valid,
    input  logic [6:0]               ev_peak,
    input  logic [HOLD_W-1:0]        ev_hold,
    output logic                     ev_ready,
    input  logic                     panic,
    input  logic                     eg_busy,
    input  logic                     eg_done,
    output logic                     note_on,
    output logic                     note_off,
    output logic [6:0]               peak,
    output logic                     playing,
    output logic [$clog2(DEPTH):0]   count,
    output logic [15:0]              notes_played
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [2:0] {IDLE, START, HOLD, STOP, WAIT_DONE} state_t;

    state_t              state;
    logic [6:0]          peak_mem [DEPTH];
    logic [HOLD_W-1:0]   hold_mem [DEPTH];
    logic [AW-1:0]       rd_ptr;
    logic [AW-1:0]       wr_ptr;
    logic [HOLD_W-1:0]   cur_hold;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [HOLD_W:0]     hold_next;
    logic [HOLD_W:0]     hold_lim;
    logic                push;
    logic                pop;
    logic                hold_done;

    // Full means no push at all, even when a pop frees a slot this cycle.
    assign ev_ready = (count != (AW+1)'(DEPTH));
    assign push     = ev_valid && ev_ready && !panic;
    assign pop      = (state == IDLE) && (count != '0) && !eg_busy && !panic;

    // Compare one bit wider so counter+1 cannot wrap; hold 0 behaves as 1.
    assign hold_next = {1'b0, hold_cnt} + 1'b1;
    assign hold_lim  = (cur_hold == '0) ? {{HOLD_W{1'b0}}, 1'b1} : {1'b0, cur_hold};
    assign hold_done = (hold_next >= hold_lim);

    // NOTE: the event storage is deliberately not reset; only pointers and
    // count define which entries are valid, so stale data is never read.
    always_ff @(posedge clk) begin
        if (push) begin
            peak_mem[wr_ptr] <= ev_peak;
            hold_mem[wr_ptr] <= ev_hold;
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (panic) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
        end
    end

    // Outputs are registered alongside the state so they never see inputs
    // combinationally.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state        <= IDLE;
            note_on      <= 1'b0;
            note_off     <= 1'b0;
            playing      <= 1'b0;
            peak         <= '0;
            cur_hold     <= '0;
            hold_cnt     <= '0;
            notes_played <= '0;
        end else begin
            note_on  <= 1'b0;
            note_off <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        cur_hold <= hold_mem[rd_ptr];
                        peak     <= peak_mem[rd_ptr];
                        note_on  <= 1'b1;
                        playing  <= 1'b1;
                        state    <= START;
                    end
                end
                START: begin
                    hold_cnt <= '0;
                    if (panic) begin
                        note_off <= 1'b1;
                        state    <= STOP;
                    end else begin
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (panic || hold_done) begin
                        note_off <= 1'b1;
                        state    <= STOP;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                STOP: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (eg_done) begin
                        notes_played <= notes_played + 1'b1;
                        playing      <= 1'b0;
                        state        <= IDLE;
                    end
                end
                default: begin
                    playing <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: reset, single note, FIFO full/ordering,
// short holds, panic and mid-note reset.
module tb_note_sequencer;

    logic        clk;
    logic        rst_b;
    logic        ev_valid;
    logic [6:0]  ev_peak;
    logic [31:0] ev_hold;
    logic        ev_ready;
    logic        panic;
    logic        eg_busy;
    logic        eg_done;
    logic        note_on;
    logic        note_off;
    logic [6:0]  peak;
    logic        playing;
    logic [2:0]  count;
    logic [15:0] notes_played;

    int n_pass  = 0;
    int n_total = 0;
    int exp_np  = 0;
    int seen;

    note_sequencer #(.DEPTH(4), .HOLD_W(32)) dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .ev_valid     (ev_valid),
        .ev_peak      (ev_peak),
        .ev_hold      (ev_hold),
        .ev_ready     (ev_ready),
        .panic        (panic),
        .eg_busy      (eg_busy),
        .eg_done      (eg_done),
        .note_on      (note_on),
        .note_off     (note_off),
        .peak         (peak),
        .playing      (playing),
        .count        (count),
        .notes_played (notes_played)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            $error("%s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_ev(input logic [6:0] p, input logic [31:0] h);
        ev_valid = 1'b1;
        ev_peak  = p;
        ev_hold  = h;
        tick();
        ev_valid = 1'b0;
    endtask

    // Starts in the note_on cycle; drives eg_done a few cycles after note_off.
    task automatic finish_note(input int exp_gap, input string tag);
        int gap;
        tick();
        ev_valid = 1'b0;
        check({tag, "_on_1cyc"}, note_on, 1'b0);
        gap = 1;
        while (!note_off && gap < 2000) begin
            tick();
            gap++;
        end
        check({tag, "_off_gap"}, gap, exp_gap);
        tick();
        tick();
        eg_done = 1'b1;
        tick();
        eg_done = 1'b0;
        exp_np++;
        check({tag, "_played"}, notes_played, exp_np);
        check({tag, "_idle"}, playing, 1'b0);
    endtask

    task automatic play_note(input logic [6:0] exp_peak, input int exp_gap, input string tag);
        int n;
        n = 0;
        while (!note_on && n < 200) begin
            tick();
            n++;
        end
        check({tag, "_on_seen"}, note_on, 1'b1);
        check({tag, "_peak"}, peak, exp_peak);
        finish_note(exp_gap, tag);
    endtask

    initial begin
        rst_b    = 1'b1;
        ev_valid = 1'b0;
        ev_peak  = '0;
        ev_hold  = '0;
        panic    = 1'b0;
        eg_busy  = 1'b0;
        eg_done  = 1'b0;

        // Reset and idle
        #2 rst_b = 1'b0;
        #1;
        check("rst_ready", ev_ready, 1'b1);
        check("rst_count", count, 0);
        check("rst_playing", playing, 1'b0);
        check("rst_peak", peak, 0);
        check("rst_np", notes_played, 0);
        repeat (3) tick();
        check("rst_ready_held", ev_ready, 1'b1);
        rst_b = 1'b1;
        seen = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (note_on || note_off) seen++;
        end
        check("idle_no_pulses", seen, 0);
        check("idle_count", count, 0);
        check("idle_playing", playing, 1'b0);

        // Single note, hold 5
        push_ev(7'd100, 32'd5);
        check("single_count", count, 1);
        check("single_no_on_yet", note_on, 1'b0);
        tick();
        check("single_on", note_on, 1'b1);
        check("single_peak", peak, 100);
        check("single_popped", count, 0);
        check("single_playing", playing, 1'b1);
        finish_note(6, "single");

        // FIFO fill while envelope busy, fifth event waits for a pop
        eg_busy = 1'b1;
        for (int i = 0; i < 4; i++) push_ev(7'((i + 1) * 10), 32'd2);
        check("full_count", count, 4);
        check("full_ready", ev_ready, 1'b0);
        ev_valid = 1'b1;
        ev_peak  = 7'd50;
        ev_hold  = 32'd2;
        tick();
        tick();
        check("full_reject", count, 4);
        check("full_no_on", note_on, 1'b0);
        eg_busy = 1'b0;
        tick();
        check("full_pop_on", note_on, 1'b1);
        check("full_pop_peak", peak, 10);
        check("full_pop_count", count, 3);
        check("full_pop_ready", ev_ready, 1'b1);
        finish_note(3, "q10");
        check("fifth_accepted", count, 4);
        play_note(7'd20, 3, "q20");
        play_note(7'd30, 3, "q30");
        play_note(7'd40, 3, "q40");
        play_note(7'd50, 3, "q50");
        check("queue_drained", count, 0);

        // Hold 0 and hold 1; second push coincides with the first pop
        push_ev(7'd7, 32'd0);
        push_ev(7'd8, 32'd1);
        check("pushpop_count", count, 1);
        play_note(7'd7, 2, "hold0");
        play_note(7'd8, 2, "hold1");

        // Panic during a long hold with two events queued
        push_ev(7'd60, 32'd1000);
        push_ev(7'd61, 32'd2);
        push_ev(7'd62, 32'd2);
        check("panic_pre_count", count, 2);
        repeat (5) tick();
        check("panic_pre_off", note_off, 1'b0);
        panic    = 1'b1;
        ev_valid = 1'b1;
        ev_peak  = 7'd63;
        tick();
        panic    = 1'b0;
        ev_valid = 1'b0;
        check("panic_off", note_off, 1'b1);
        check("panic_count", count, 0);
        check("panic_peak", peak, 60);
        tick();
        tick();
        eg_done = 1'b1;
        tick();
        eg_done = 1'b0;
        exp_np++;
        check("panic_played", notes_played, exp_np);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (note_on) seen++;
        end
        check("panic_no_more_on", seen, 0);

        // Reset while waiting for done with two events queued
        push_ev(7'd70, 32'd2);
        push_ev(7'd71, 32'd2);
        push_ev(7'd72, 32'd2);
        seen = 0;
        while (!note_off && seen < 100) begin
            tick();
            seen++;
        end
        check("rstmid_off_seen", note_off, 1'b1);
        tick();
        check("rstmid_pre_count", count, 2);
        check("rstmid_pre_playing", playing, 1'b1);
        #2 rst_b = 1'b0;
        #1;
        exp_np = 0;
        check("rstmid_playing", playing, 1'b0);
        check("rstmid_count", count, 0);
        check("rstmid_np", notes_played, exp_np);
        check("rstmid_peak", peak, 0);
        check("rstmid_ready", ev_ready, 1'b1);
        check("rstmid_off", note_off, 1'b0);
        tick();
        rst_b   = 1'b1;
        eg_done = 1'b1;
        tick();
        eg_done = 1'b0;
        check("rstmid_done_ignored", notes_played, exp_np);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (note_on) seen++;
        end
        check("rstmid_fifo_lost", seen, 0);
        check("rstmid_final_count", count, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
